// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the MIPS fetch stage.
// Holds the PC and picks the next one (jump > branch > sequential). It runs either
// continuously or one step per rising edge of i_step, honours hazard stalls, halt
// and soft clear, and keeps saturating cycle/fetch counters for the debug unit.
module pc_sequencer #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    PC_INC       = 4,
  parameter int                    ALIGN_BITS   = 2,
  parameter int                    CNT_WIDTH    = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic                  i_step,
  input  logic                  i_stall,
  input  logic                  i_jump_en,
  input  logic [DATA_WIDTH-1:0] i_jump_addr,
  input  logic                  i_branch_en,
  input  logic [DATA_WIDTH-1:0] i_branch_addr,
  input  logic                  i_halt,
  input  logic                  i_clear,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_pc_plus,
  output logic                  o_valid,
  output logic                  o_halted,
  output logic                  o_misalign,
  output logic [CNT_WIDTH-1:0]  o_cycle_count,
  output logic [CNT_WIDTH-1:0]  o_fetch_count
);

  // Low address bits that must be zero in an accepted redirect target.
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK =
    (DATA_WIDTH'(1) << ALIGN_BITS) - DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] INC = DATA_WIDTH'(PC_INC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) return v;
    else    return v + CNT_WIDTH'(1);
  endfunction

  // Redirect targets are forced onto the alignment boundary.
  function automatic logic [DATA_WIDTH-1:0] align_down(input logic [DATA_WIDTH-1:0] a);
    return a & ~ALIGN_MASK;
  endfunction

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] w_pc_next;
  logic                  r_valid;
  logic                  r_misalign;
  logic                  w_misalign_next;
  logic [CNT_WIDTH-1:0]  r_cycle_cnt;
  logic [CNT_WIDTH-1:0]  w_cycle_next;
  logic [CNT_WIDTH-1:0]  r_fetch_cnt;
  logic [CNT_WIDTH-1:0]  w_fetch_next;
  logic                  r_step_d;
  logic                  r_pend;
  logic                  w_pend_next;

  logic                  w_step_rise;
  logic                  w_redirect;
  logic [DATA_WIDTH-1:0] w_target;
  logic                  w_target_mis;
  logic                  w_exec;
  logic                  w_take_redirect;
  logic                  w_take_seq;
  logic                  w_update;
  logic                  w_counting;

  assign w_step_rise  = i_step & ~r_step_d;
  assign w_redirect   = i_jump_en | i_branch_en;
  assign w_target     = i_jump_en ? i_jump_addr : i_branch_addr;
  assign w_target_mis = |(w_target & ALIGN_MASK);
  assign w_update     = w_take_redirect | w_take_seq;
  assign w_counting   = (r_state == S_RUN) || (r_state == S_STEP);

  // FSM state register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next state and PC-update decision: halt beats redirect beats stall beats advance.
  always_comb begin
    w_state_next    = r_state;
    w_pend_next     = r_pend;
    w_exec          = 1'b0;
    w_take_redirect = 1'b0;
    w_take_seq      = 1'b0;
    if (i_clear) begin
      w_state_next = S_IDLE;
      w_pend_next  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) w_state_next = i_mode ? S_STEP : S_RUN;
        end
        S_RUN: begin
          w_exec = 1'b1;
        end
        S_STEP: begin
          // A new edge while a step is still pending merges into that step.
          w_exec      = r_pend;
          w_pend_next = r_pend | w_step_rise;
        end
        S_HALTED: begin
          w_state_next = S_HALTED;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
      if (w_exec) begin
        if (i_halt) begin
          w_state_next = S_HALTED;
          w_pend_next  = 1'b0;
        end else if (w_redirect) begin
          // A flush overrides the hazard bubble.
          w_take_redirect = 1'b1;
          w_pend_next     = 1'b0;
        end else if (!i_stall) begin
          w_take_seq  = 1'b1;
          w_pend_next = 1'b0;
        end
      end
    end
  end

  // Datapath next values: PC, sticky misalign flag and saturating counters.
  always_comb begin
    w_pc_next       = r_pc;
    w_misalign_next = r_misalign;
    w_cycle_next    = r_cycle_cnt;
    w_fetch_next    = r_fetch_cnt;
    if (i_clear) begin
      w_pc_next       = RESET_VECTOR;
      w_misalign_next = 1'b0;
      w_cycle_next    = '0;
      w_fetch_next    = '0;
    end else begin
      if (w_take_redirect) begin
        w_pc_next       = align_down(w_target);
        w_misalign_next = r_misalign | w_target_mis;
      end else if (w_take_seq) begin
        w_pc_next = r_pc + INC;
      end
      if (w_counting) w_cycle_next = sat_inc(r_cycle_cnt);
      if (w_update)   w_fetch_next = sat_inc(r_fetch_cnt);
    end
  end

  // Datapath and step-tracking registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_pc        <= RESET_VECTOR;
      r_valid     <= 1'b0;
      r_misalign  <= 1'b0;
      r_cycle_cnt <= '0;
      r_fetch_cnt <= '0;
      r_step_d    <= 1'b0;
      r_pend      <= 1'b0;
    end else begin
      r_pc        <= w_pc_next;
      r_valid     <= w_update;
      r_misalign  <= w_misalign_next;
      r_cycle_cnt <= w_cycle_next;
      r_fetch_cnt <= w_fetch_next;
      r_step_d    <= i_step;
      r_pend      <= w_pend_next;
    end
  end

  assign o_pc          = r_pc;
  assign o_pc_plus     = r_pc + INC;
  assign o_valid       = r_valid;
  assign o_halted      = (r_state == S_HALTED);
  assign o_misalign    = r_misalign;
  assign o_cycle_count = r_cycle_cnt;
  assign o_fetch_count = r_fetch_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a 32-bit instance and an 8-bit/4-bit-counter
// instance share one stimulus stream; a behavioural model predicts every cycle.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, mode, step, stall, jen, ben, halt, clr;
  logic [31:0] jaddr, baddr;

  logic [31:0] a_pc, a_pcp, a_cyc, a_fet;
  logic        a_valid, a_halted, a_mis;
  logic [7:0]  b_pc, b_pcp;
  logic [3:0]  b_cyc, b_fet;
  logic        b_valid, b_halted, b_mis;

  pc_sequencer #(.DATA_WIDTH(32), .CNT_WIDTH(32)) u_dut_a (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_mode(mode), .i_step(step),
    .i_stall(stall), .i_jump_en(jen), .i_jump_addr(jaddr), .i_branch_en(ben),
    .i_branch_addr(baddr), .i_halt(halt), .i_clear(clr),
    .o_pc(a_pc), .o_pc_plus(a_pcp), .o_valid(a_valid), .o_halted(a_halted),
    .o_misalign(a_mis), .o_cycle_count(a_cyc), .o_fetch_count(a_fet));

  pc_sequencer #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_dut_b (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_mode(mode), .i_step(step),
    .i_stall(stall), .i_jump_en(jen), .i_jump_addr(jaddr[7:0]), .i_branch_en(ben),
    .i_branch_addr(baddr[7:0]), .i_halt(halt), .i_clear(clr),
    .o_pc(b_pc), .o_pc_plus(b_pcp), .o_valid(b_valid), .o_halted(b_halted),
    .o_misalign(b_mis), .o_cycle_count(b_cyc), .o_fetch_count(b_fet));

  typedef struct {
    logic [31:0] pc, pcp, cyc, fet;
    logic        valid, halted, mis;
  } snap_t;

  snap_t       qa[$];
  snap_t       qb[$];
  logic [31:0] q_fetch[$];

  int n_vec = 0;
  int n_err = 0;

  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;
  int          m_st[2];
  logic [31:0] m_pc[2], m_cyc[2], m_fet[2];
  logic        m_valid[2], m_mis[2], m_pend[2], m_stepd[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v, input logic [31:0] maxv);
    return (v == maxv) ? v : v + 32'd1;
  endfunction

  // Behavioural reference: one clock of the sequencer for instance k.
  task automatic model_step(input int k);
    logic [31:0] pmask, cmax, t;
    logic        rise, go, done;
    pmask = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    cmax  = (k == 0) ? 32'hFFFF_FFFF : 32'd15;
    if (!rst_n) begin
      m_st[k] = M_IDLE; m_pc[k] = 0; m_cyc[k] = 0; m_fet[k] = 0;
      m_valid[k] = 0; m_mis[k] = 0; m_pend[k] = 0; m_stepd[k] = 0;
      return;
    end
    rise       = step && !m_stepd[k];
    m_stepd[k] = step;
    m_valid[k] = 0;
    if (clr) begin
      m_st[k] = M_IDLE; m_pc[k] = 0; m_cyc[k] = 0; m_fet[k] = 0;
      m_mis[k] = 0; m_pend[k] = 0;
      return;
    end
    if (m_st[k] == M_RUN || m_st[k] == M_STEP) m_cyc[k] = sat(m_cyc[k], cmax);
    go = (m_st[k] == M_RUN) || (m_st[k] == M_STEP && m_pend[k]);
    if (m_st[k] == M_STEP && !m_pend[k]) begin
      if (rise) m_pend[k] = 1;
    end else if (go) begin
      done = 1;
      if (halt) m_st[k] = M_HALT;
      else if (jen || ben) begin
        t = (jen ? jaddr : baddr) & pmask;
        if (t[1:0] != 2'b00) m_mis[k] = 1;
        m_pc[k] = t & ~32'h3;
        m_valid[k] = 1; m_fet[k] = sat(m_fet[k], cmax);
      end else if (!stall) begin
        m_pc[k] = (m_pc[k] + 32'd4) & pmask;
        m_valid[k] = 1; m_fet[k] = sat(m_fet[k], cmax);
      end else done = 0;
      if (done) m_pend[k] = 0;
    end else if (m_st[k] == M_IDLE && start) begin
      m_st[k] = mode ? M_STEP : M_RUN;
    end
  endtask

  function automatic snap_t snap(input int k);
    snap_t s;
    logic [31:0] pmask;
    pmask    = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    s.pc     = m_pc[k];
    s.pcp    = (m_pc[k] + 32'd4) & pmask;
    s.cyc    = m_cyc[k];
    s.fet    = m_fet[k];
    s.valid  = m_valid[k];
    s.halted = (m_st[k] == M_HALT);
    s.mis    = m_mis[k];
    return s;
  endfunction

  // Predict the effect of the inputs now applied, then move to the next drive slot.
  task automatic commit();
    model_step(0);
    model_step(1);
    qa.push_back(snap(0));
    qb.push_back(snap(1));
    if (m_valid[0]) q_fetch.push_back(m_pc[0]);
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    start = 0; mode = 0; step = 0; stall = 0; jen = 0; ben = 0;
    halt = 0; clr = 0; jaddr = 0; baddr = 0;
  endtask

  // Monitor: sample just after each rising edge and compare with the scoreboard.
  initial begin
    snap_t ea, eb;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() == 0 || qb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
      end else begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("a_pc", a_pc, ea.pc);
        chk("a_pc_plus", a_pcp, ea.pcp);
        chk("a_valid", {31'b0, a_valid}, {31'b0, ea.valid});
        chk("a_halted", {31'b0, a_halted}, {31'b0, ea.halted});
        chk("a_misalign", {31'b0, a_mis}, {31'b0, ea.mis});
        chk("a_cycle_count", a_cyc, ea.cyc);
        chk("a_fetch_count", a_fet, ea.fet);
        chk("b_pc", {24'b0, b_pc}, eb.pc);
        chk("b_pc_plus", {24'b0, b_pcp}, eb.pcp);
        chk("b_valid", {31'b0, b_valid}, {31'b0, eb.valid});
        chk("b_halted", {31'b0, b_halted}, {31'b0, eb.halted});
        chk("b_misalign", {31'b0, b_mis}, {31'b0, eb.mis});
        chk("b_cycle_count", {28'b0, b_cyc}, eb.cyc);
        chk("b_fetch_count", {28'b0, b_fet}, eb.fet);
      end
      if (a_valid === 1'b1) begin
        if (q_fetch.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL fetch_pc: got valid with pc %h expected no update", a_pc);
        end else begin
          chk("fetch_pc", a_pc, q_fetch.pop_front());
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by random traffic.
  initial begin
    rst_n = 0;
    idle_inputs();
    repeat (2) commit();
    rst_n = 1;
    commit();

    // Continuous run from reset.
    start = 1; mode = 0; commit();
    start = 0; repeat (5) commit();

    // Stall hold, then a flush through a stall.
    jen = 1; jaddr = 32'h10; commit(); jen = 0;
    stall = 1; repeat (3) commit();
    jen = 1; jaddr = 32'h40; commit(); jen = 0; stall = 0;

    // Jump beats branch; misaligned branch.
    jen = 1; jaddr = 32'h80; ben = 1; baddr = 32'h20; commit(); jen = 0;
    baddr = 32'h22; commit(); ben = 0;

    // Halt at 0x0C with redirect and stall also requested, then frozen hold.
    jen = 1; jaddr = 32'h0C; commit();
    jaddr = 32'h100; halt = 1; stall = 1; commit();
    halt = 0; stall = 0; jen = 0;
    repeat (10) commit();
    jen = 1; jaddr = 32'h200; repeat (10) commit(); jen = 0;

    // Clear with a simultaneous start: start must be ignored.
    clr = 1; start = 1; commit(); clr = 0; start = 0;
    repeat (2) commit();

    // Single-step mode.
    start = 1; mode = 1; commit(); start = 0; mode = 0;
    step = 1; repeat (10) commit(); step = 0; commit();
    repeat (2) begin step = 1; commit(); step = 0; repeat (3) commit(); end
    stall = 1; step = 1; commit(); step = 0; repeat (3) commit(); stall = 0; repeat (2) commit();
    stall = 1; step = 1; commit(); step = 0; commit(); step = 1; commit(); step = 0; commit();
    stall = 0; repeat (3) commit();
    jen = 1; jaddr = 32'h204; repeat (3) commit();
    step = 1; commit(); step = 0; commit(); jen = 0; commit();
    halt = 1; commit(); step = 1; commit(); step = 0; commit(); halt = 0; commit();
    clr = 1; commit(); clr = 0;

    // Run to the top of the 8-bit space so the narrow instance wraps.
    start = 1; commit(); start = 0;
    jen = 1; jaddr = 32'hFC; commit(); jen = 0;
    repeat (3) commit();

    // Reset dropped between clock edges takes effect immediately.
    #1 rst_n = 0;
    #1;
    chk("async_pc_a", a_pc, 32'h0);
    chk("async_pc_b", {24'b0, b_pc}, 32'h0);
    chk("async_fetch_a", a_fet, 32'h0);
    chk("async_cycle_a", a_cyc, 32'h0);
    chk("async_valid_a", {31'b0, a_valid}, 32'h0);
    commit();
    rst_n = 1; commit();

    // Random traffic.
    repeat (400) begin
      start = ($urandom % 4) == 0;
      mode  = $urandom % 2;
      step  = $urandom % 2;
      stall = ($urandom % 3) == 0;
      jen   = ($urandom % 6) == 0;
      jaddr = $urandom;
      ben   = ($urandom % 5) == 0;
      baddr = $urandom;
      halt  = ($urandom % 25) == 0;
      clr   = ($urandom % 30) == 0;
      commit();
    end
    idle_inputs();
    commit();

    chk("fetch_queue_drained", q_fetch.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
